if_fetch_resp: RTL

- Responder side of the fetch-address interface: consumes the PC driven by the fetch stage each cycle.
- Issues a read to a synchronous instruction memory (1-cycle read latency) and buffers returned words with their PC in a small FIFO.
- Presents {pc, inst} to decode under a valid/ready handshake.
- Generates the stall back to the PC register and handles redirect flushes.

---
 rtl/if_fetch_resp.sv | 110 +++++++++++
 1 files changed

// File: rtl/if_fetch_resp.sv
// Fetch-address responder: issues PCs to a 1-cycle synchronous instruction memory,
// buffers {pc, inst, err} in a small FIFO and hands them to decode with valid/ready.
module if_fetch_resp #(
  parameter logic [31:0] PC_BASE    = 32'h0000_3000,
  parameter int          IMEM_AW    = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic               clk_cpu,
  input  logic               rstn,
  input  logic [31:0]        pcd,
  input  logic               redirect,
  output logic               stall,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               inst_valid,
  output logic [31:0]        inst_out,
  output logic [31:0]        pc_out,
  output logic               addr_err,
  input  logic               id_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          inflight_v_q, inflight_v_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_err_q, inflight_err_d;

  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] inst_mem [FIFO_DEPTH];
  logic        err_mem  [FIFO_DEPTH];

  logic [29:0]   woff;
  logic          legal;
  logic          head_v;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW-1:0] occ;

  // Word offset is only meaningful for aligned PCs; unaligned ones are illegal anyway.
  assign woff  = pcd[31:2] - PC_BASE[31:2];
  assign legal = (pcd[1:0] == 2'b00) && (pcd >= PC_BASE) && (woff[29:IMEM_AW] == '0);

  assign head_v = rstn && (count_q != '0);
  assign pop    = head_v & id_ready & ~redirect;
  assign push   = inflight_v_q & ~redirect;

  // Occupancy counts the in-flight read so a full FIFO can never be overrun.
  assign occ   = count_q + CW'(inflight_v_q) - CW'(pop);
  assign stall = rstn & ~redirect & (occ >= CW'(FIFO_DEPTH));
  assign issue = ~stall & ~redirect & rstn;

  assign imem_en   = issue & legal;
  assign imem_addr = woff[IMEM_AW-1:0];

  assign inst_valid = head_v;
  assign inst_out   = head_v ? inst_mem[rd_ptr_q] : NOP_INST;
  assign pc_out     = head_v ? pc_mem[rd_ptr_q]   : 32'h0;
  assign addr_err   = head_v ? err_mem[rd_ptr_q]  : 1'b0;

  always_comb begin
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    inflight_v_d   = issue;
    inflight_pc_d  = pcd;
    inflight_err_d = ~legal;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (!rstn) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      inflight_v_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      inflight_v_q <= inflight_v_d;
    end
  end

  // Datapath storage carries no reset; validity is tracked by count/inflight_v only.
  always_ff @(posedge clk_cpu) begin
    inflight_pc_q  <= inflight_pc_d;
    inflight_err_q <= inflight_err_d;
    if (push && rstn) begin
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
      inst_mem[wr_ptr_q] <= inflight_err_q ? NOP_INST : imem_rdata;
      err_mem[wr_ptr_q]  <= inflight_err_q;
    end
  end

endmodule
